// File: rtl/pic_prio.sv
// Fixed-priority interrupt controller: edge/level sources, enable mask,
// single non-nesting in-progress window opened at decode, closed by ertn.
module pic_prio #(
  parameter int NUM_SRC = 8,
  parameter int ID_W = $clog2(NUM_SRC),
  parameter logic [NUM_SRC-1:0] EDGE_SRC = '0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NUM_SRC-1:0] src_intr_sync,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               vld_d,
  input  logic               ertn_w,
  output logic               intr_sync,
  output logic               intr_sync_pulse,
  output logic [ID_W-1:0]    intr_id,
  output logic [NUM_SRC-1:0] intr_pend
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_INPROG = 1'b1;

  logic [0:0]         state;
  logic [NUM_SRC-1:0] edge_q;
  logic [NUM_SRC-1:0] hist_q;
  logic [ID_W-1:0]    id_q;

  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] clr;
  logic [ID_W-1:0]    win;
  logic               found;
  logic               take;

  assign rise = src_intr_sync & ~hist_q & EDGE_SRC;
  assign intr_pend = (edge_q & EDGE_SRC)
                   | (src_intr_sync & ~EDGE_SRC);
  assign elig = intr_pend & src_en;

  // lowest index wins
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i] && !found) begin
        win   = ID_W'(i);
        found = 1'b1;
      end
    end
  end

  assign take = (state == ST_IDLE) & found
              & vld_d & ~ertn_w;

  assign clr = take ? (NUM_SRC'(1) << win) : '0;

  // a fresh edge in the take cycle beats the clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      edge_q <= '0;
      hist_q <= '0;
    end else begin
      edge_q <= ((edge_q & ~clr) | rise) & EDGE_SRC;
      hist_q <= src_intr_sync;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      id_q  <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (take) begin
            state <= ST_INPROG;
            id_q  <= win;
          end
        end
        (state == ST_INPROG): begin
          if (ertn_w) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign intr_sync       = take | (state == ST_INPROG);
  assign intr_sync_pulse = take;
  assign intr_id         = take ? win : id_q;

endmodule

// File: tb/tb_pic_prio.sv
// Directed vector bench for pic_prio: table of per-cycle stimulus and
// expected outputs, plus hand sequences around reset.
module tb_pic_prio;

  localparam int N = 8;
  localparam int W = 3;
  localparam logic [N-1:0] EDGES = 8'b0010_0010;

  logic         clk;
  logic         resetn;
  logic [N-1:0] src;
  logic [N-1:0] en;
  logic         vld;
  logic         ertn;
  logic         sync;
  logic         pulse;
  logic [W-1:0] id;
  logic [N-1:0] pend;

  int n_pass;
  int n_tot;

  pic_prio #(
    .NUM_SRC(N),
    .ID_W(W),
    .EDGE_SRC(EDGES)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .src_intr_sync(src),
    .src_en(en),
    .vld_d(vld),
    .ertn_w(ertn),
    .intr_sync(sync),
    .intr_sync_pulse(pulse),
    .intr_id(id),
    .intr_pend(pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] src;
    logic [N-1:0] en;
    logic         vld;
    logic         ertn;
    logic         sync;
    logic         pulse;
    logic [W-1:0] id;
    logic [N-1:0] pend;
  } vec_t;

  vec_t vec [29];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic check_all(input string tag,
                           input logic s, input logic p,
                           input logic [W-1:0] i,
                           input logic [N-1:0] pd);
    check({tag, " sync"}, 32'(sync), 32'(s));
    check({tag, " pulse"}, 32'(pulse), 32'(p));
    check({tag, " id"}, 32'(id), 32'(i));
    check({tag, " pend"}, 32'(pend), 32'(pd));
  endtask

  task automatic drive(input logic r, input logic [N-1:0] s,
                       input logic [N-1:0] e,
                       input logic v, input logic x);
    @(negedge clk);
    resetn = r;
    src    = s;
    en     = e;
    vld    = v;
    ertn   = x;
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_tot  = 0;
    //          src    en     vld ertn sync pul id pend
    vec[0]  = '{8'h08, 8'hFF, 1, 0, 1, 1, 3'd3, 8'h08};
    vec[1]  = '{8'h08, 8'hFF, 1, 0, 1, 0, 3'd3, 8'h08};
    vec[2]  = '{8'h08, 8'hFF, 1, 1, 1, 0, 3'd3, 8'h08};
    vec[3]  = '{8'h00, 8'hFF, 0, 0, 0, 0, 3'd3, 8'h00};
    vec[4]  = '{8'h24, 8'hFF, 0, 0, 0, 0, 3'd3, 8'h04};
    vec[5]  = '{8'h24, 8'hFF, 1, 0, 1, 1, 3'd2, 8'h24};
    vec[6]  = '{8'h04, 8'hFF, 1, 1, 1, 0, 3'd2, 8'h24};
    vec[7]  = '{8'h00, 8'hFF, 1, 0, 1, 1, 3'd5, 8'h20};
    vec[8]  = '{8'h00, 8'hFF, 0, 1, 1, 0, 3'd5, 8'h00};
    vec[9]  = '{8'h00, 8'hFF, 1, 0, 0, 0, 3'd5, 8'h00};
    vec[10] = '{8'h10, 8'hFF, 1, 0, 1, 1, 3'd4, 8'h10};
    vec[11] = '{8'h12, 8'hFF, 1, 0, 1, 0, 3'd4, 8'h10};
    vec[12] = '{8'h10, 8'hFF, 1, 0, 1, 0, 3'd4, 8'h12};
    vec[13] = '{8'h00, 8'hFF, 1, 1, 1, 0, 3'd4, 8'h02};
    vec[14] = '{8'h00, 8'hFF, 1, 0, 1, 1, 3'd1, 8'h02};
    vec[15] = '{8'h00, 8'hFF, 0, 1, 1, 0, 3'd1, 8'h00};
    vec[16] = '{8'h40, 8'hFF, 1, 1, 0, 0, 3'd1, 8'h40};
    vec[17] = '{8'h40, 8'hFF, 1, 0, 1, 1, 3'd6, 8'h40};
    vec[18] = '{8'h00, 8'hFF, 0, 1, 1, 0, 3'd6, 8'h00};
    vec[19] = '{8'h01, 8'hFE, 1, 0, 0, 0, 3'd6, 8'h01};
    vec[20] = '{8'h01, 8'hFF, 1, 0, 1, 1, 3'd0, 8'h01};
    vec[21] = '{8'h01, 8'h00, 1, 0, 1, 0, 3'd0, 8'h01};
    vec[22] = '{8'h00, 8'hFF, 0, 1, 1, 0, 3'd0, 8'h00};
    vec[23] = '{8'h20, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h00};
    vec[24] = '{8'h00, 8'hFF, 0, 0, 0, 0, 3'd0, 8'h20};
    vec[25] = '{8'h20, 8'hFF, 1, 0, 1, 1, 3'd5, 8'h20};
    vec[26] = '{8'h00, 8'hFF, 0, 1, 1, 0, 3'd5, 8'h20};
    vec[27] = '{8'h00, 8'hFF, 1, 0, 1, 1, 3'd5, 8'h20};
    vec[28] = '{8'h00, 8'hFF, 0, 1, 1, 0, 3'd5, 8'h00};

    resetn = 1'b0;
    src    = '0;
    en     = '0;
    vld    = 1'b0;
    ertn   = 1'b0;

    // reset: level source visible, edge source hidden
    drive(0, 8'h0A, 8'hFF, 0, 0);
    check_all("reset", 0, 0, 3'd0, 8'h08);
    drive(0, 8'h00, 8'hFF, 0, 0);
    drive(1, 8'h00, 8'hFF, 0, 0);

    for (int k = 0; k < 29; k++) begin
      drive(1, vec[k].src, vec[k].en, vec[k].vld, vec[k].ertn);
      check_all($sformatf("v%0d", k), vec[k].sync,
                vec[k].pulse, vec[k].id, vec[k].pend);
    end

    // reset in the middle of an in-progress window
    drive(1, 8'h08, 8'hFF, 1, 0);
    check_all("pre_rst take", 1, 1, 3'd3, 8'h08);
    drive(1, 8'h08, 8'hFF, 0, 0);
    check_all("inprog", 1, 0, 3'd3, 8'h08);
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    check_all("async rst", 0, 0, 3'd0, 8'h08);
    drive(1, 8'h08, 8'hFF, 1, 0);
    check_all("retake", 1, 1, 3'd3, 8'h08);

    // edge source high at reset release latches in first cycle
    drive(0, 8'h02, 8'hFF, 0, 0);
    check_all("rst edge", 0, 0, 3'd0, 8'h00);
    drive(1, 8'h02, 8'hFF, 0, 0);
    check_all("rel edge", 0, 0, 3'd0, 8'h00);
    drive(1, 8'h02, 8'hFF, 1, 0);
    check_all("edge take", 1, 1, 3'd1, 8'h02);
    drive(1, 8'h02, 8'hFF, 0, 1);
    check_all("edge clr", 1, 0, 3'd1, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
